// File: rtl/jt12_dac_interp_pkg.sv
// Shared defaults for the DAC interpolator slice.
// The sample width default matches the sigma-delta DAC stage that consumes dout.
package jt12_dac_interp_pkg;

  localparam int DAC_WIDTH_DEF = 11;  // sample width, two's complement
  localparam int DAC_LOG2R_DEF = 4;   // log2 of clk cycles per input sample

endpackage

// File: rtl/jt12_dac_interp.sv
// Linear interpolator between the mixer output and the sigma-delta DAC modulator.
// Takes one signed sample every R=2**LOG2R clocks over valid/ready and ramps dout
// linearly from the previous target to the new one, one output per clock.
// A one-entry buffer (hold) decouples the producer from the slot boundary; if it is
// empty when a slot ends, the output holds the last target and underrun is flagged.
module jt12_dac_interp
  import jt12_dac_interp_pkg::*;
#(
  parameter int width = DAC_WIDTH_DEF,
  parameter int LOG2R = DAC_LOG2R_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [width-1:0] din,
  input  logic                    din_valid,
  output logic                    din_ready,
  output logic signed [width-1:0] dout,
  output logic                    wrap,
  output logic                    starved,
  output logic                    underrun
);

  // Accumulator keeps LOG2R fraction bits so a full-scale step divides exactly.
  localparam int AW = width + LOG2R;
  // Difference of two width-bit samples needs one extra bit.
  localparam int SW = width + 1;
  localparam logic [LOG2R-1:0] PH_LAST = {LOG2R{1'b1}};

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_STARVED = 2'd2;

  logic [1:0]              state_q, state_d;
  logic signed [width-1:0] hold_q, hold_d;
  logic                    hold_vld_q, hold_vld_d;
  logic signed [width-1:0] tgt_q, tgt_d;
  logic signed [SW-1:0]    step_q, step_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic [LOG2R-1:0]        ph_q, ph_d;

  logic ph_last_s;
  logic active_s;
  logic wrap_s;
  logic take_s;
  logic load_s;

  assign ph_last_s = (ph_q == PH_LAST);
  assign active_s  = (state_q == ST_RUN) || (state_q == ST_STARVED);
  assign wrap_s    = active_s && ph_last_s;
  assign take_s    = din_valid && din_ready;
  // hold moves into tgt on the first edge out of EMPTY or on any slot boundary
  assign load_s    = hold_vld_q && ((state_q == ST_EMPTY) || wrap_s);

  // Floor division by R is just dropping the fraction bits of the accumulator.
  assign dout = acc_q[AW-1:LOG2R];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: leave EMPTY on the first sample, decide RUN/STARVED at each slot end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: begin
        if (hold_vld_q) state_d = ST_RUN;
        else            state_d = ST_EMPTY;
      end
      ST_RUN, ST_STARVED: begin
        if (wrap_s) state_d = hold_vld_q ? ST_RUN : ST_STARVED;
        else        state_d = state_q;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Outputs: handshake, slot strobe and the starvation flags.
  always_comb begin
    din_ready = ~hold_vld_q & ~rst;
    wrap      = 1'b0;
    starved   = 1'b0;
    underrun  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        wrap = 1'b0;
      end
      ST_RUN: begin
        wrap     = ph_last_s;
        underrun = ph_last_s & ~hold_vld_q;
      end
      ST_STARVED: begin
        wrap    = ph_last_s;
        starved = 1'b1;
      end
      default: begin
        wrap = 1'b0;
      end
    endcase
  end

  // Datapath next-state: input buffer, target/step reload and the linear ramp.
  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    tgt_d      = tgt_q;
    step_d     = step_q;
    acc_d      = acc_q;
    ph_d       = ph_q;

    // take and load never coincide: take needs an empty hold, load a full one
    if (load_s) begin
      hold_vld_d = 1'b0;
      tgt_d      = hold_q;
    end else if (take_s) begin
      hold_d     = din;
      hold_vld_d = 1'b1;
    end else begin
      hold_vld_d = hold_vld_q;
    end

    case (state_q)
      ST_EMPTY: begin
        // first ramp starts from 0, so the step is the sample itself
        ph_d  = '0;
        acc_d = '0;
        if (hold_vld_q) step_d = SW'(hold_q);
        else            step_d = step_q;
      end
      ST_RUN, ST_STARVED: begin
        if (wrap_s) begin
          // snap exactly onto the target so rounding never accumulates across slots
          ph_d  = '0;
          acc_d = {tgt_q, {LOG2R{1'b0}}};
          if (hold_vld_q) step_d = SW'(hold_q) - SW'(tgt_q);
          else            step_d = '0;
        end else begin
          ph_d  = ph_q + LOG2R'(1'b1);
          acc_d = acc_q + AW'(step_q);
        end
      end
      default: begin
        ph_d   = '0;
        acc_d  = '0;
        step_d = '0;
      end
    endcase
  end

  // Datapath registers; reset drops both the buffered sample and any ramp in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
      tgt_q      <= '0;
      step_q     <= '0;
      acc_q      <= '0;
      ph_q       <= '0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      tgt_q      <= tgt_d;
      step_q     <= step_d;
      acc_q      <= acc_d;
      ph_q       <= ph_d;
    end
  end

endmodule

// File: tb/tb_jt12_dac_interp.sv
// Directed bench for jt12_dac_interp with width=11, LOG2R=2 (R=4).
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_jt12_dac_interp;

  localparam int W  = 11;
  localparam int LR = 2;

  logic                clk;
  logic                rst;
  logic signed [W-1:0] din;
  logic                din_valid;
  logic                din_ready;
  logic signed [W-1:0] dout;
  logic                wrap;
  logic                starved;
  logic                underrun;

  int n_vec;
  int n_miss;
  int cyc_n;

  jt12_dac_interp #(.width(W), .LOG2R(LR)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .dout      (dout),
    .wrap      (wrap),
    .starved   (starved),
    .underrun  (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every vector and reports mismatches.
  task automatic check_eq(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @cyc%0d: got %0d, expected %0d", tag, cyc_n, got, exp);
    end
  endtask

  // Advance one rising edge, then check the per-cycle outputs on the falling edge.
  task automatic step_chk(input string tag, input int e_dout, input int e_wrap,
                          input int e_und, input int e_stv);
    @(negedge clk);
    cyc_n++;
    check_eq({tag, ".dout"},     int'(dout),     e_dout);
    check_eq({tag, ".wrap"},     int'(wrap),     e_wrap);
    check_eq({tag, ".underrun"}, int'(underrun), e_und);
    check_eq({tag, ".starved"},  int'(starved),  e_stv);
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    cyc_n     = 0;
    rst       = 1'b1;
    din       = '0;
    din_valid = 1'b0;

    // 1: reset held 3 cycles
    repeat (3) @(negedge clk);
    check_eq("rst.din_ready", int'(din_ready), 0);
    rst = 1'b0;
    step_chk("rst", 0, 0, 0, 0);
    check_eq("rst.din_ready_rel", int'(din_ready), 1);

    // 2: single sample 400 from EMPTY, then starve
    din = 11'sd400; din_valid = 1'b1;
    step_chk("t2.acc", 0, 0, 0, 0);
    din_valid = 1'b0;
    check_eq("t2.ready_full", int'(din_ready), 0);
    step_chk("t2.r0", 0,   0, 0, 0);
    step_chk("t2.r1", 100, 0, 0, 0);
    step_chk("t2.r2", 200, 0, 0, 0);
    step_chk("t2.r3", 300, 1, 1, 0);
    step_chk("t2.s0", 400, 0, 0, 1);
    step_chk("t2.s1", 400, 0, 0, 1);
    step_chk("t2.s2", 400, 0, 0, 1);
    step_chk("t2.s3", 400, 1, 0, 1);

    // sample offered on a starved wrap edge lands in hold only; no pass-through
    din = 11'sd400; din_valid = 1'b1;
    step_chk("t2.np0", 400, 0, 0, 1);
    din_valid = 1'b0;
    step_chk("t2.np1", 400, 0, 0, 1);
    step_chk("t2.np2", 400, 0, 0, 1);
    step_chk("t2.np3", 400, 1, 0, 1);
    step_chk("t2.clr", 400, 0, 0, 0);

    // 3: stream -400 in time -> 400,200,0,-200 then -400
    din = -11'sd400; din_valid = 1'b1;
    step_chk("t3.h1", 400, 0, 0, 0);
    din_valid = 1'b0;
    step_chk("t3.h2", 400, 0, 0, 0);
    step_chk("t3.h3", 400, 1, 0, 0);
    step_chk("t3.r0", 400, 0, 0, 0);
    din = -11'sd1024; din_valid = 1'b1;
    step_chk("t3.r1", 200, 0, 0, 0);
    din_valid = 1'b0;
    step_chk("t3.r2", 0,    0, 0, 0);
    step_chk("t3.r3", -200, 1, 0, 0);

    // ramp -400 -> -1024 (step -624) while 1023 is supplied
    step_chk("t4.p0", -400, 0, 0, 0);
    din = 11'sd1023; din_valid = 1'b1;
    step_chk("t4.p1", -556, 0, 0, 0);
    din_valid = 1'b0;
    step_chk("t4.p2", -712, 0, 0, 0);
    step_chk("t4.p3", -868, 1, 0, 0);

    // 4: full-scale step 2047 with floor rounding; 5: back-to-back 100, 400
    step_chk("t4.r0", -1024, 0, 0, 0);
    din = 11'sd100; din_valid = 1'b1;
    check_eq("t5.ready0", int'(din_ready), 1);
    step_chk("t4.r1", -513, 0, 0, 0);
    din = 11'sd400; din_valid = 1'b1;
    check_eq("t5.stall1", int'(din_ready), 0);
    step_chk("t4.r2", -1, 0, 0, 0);
    check_eq("t5.stall2", int'(din_ready), 0);
    step_chk("t4.r3", 511, 1, 0, 0);
    check_eq("t5.stall_wrap", int'(din_ready), 0);
    step_chk("t4.end", 1023, 0, 0, 0);
    check_eq("t5.ready_again", int'(din_ready), 1);
    step_chk("t5.a1", 792, 0, 0, 0);
    din_valid = 1'b0;
    check_eq("t5.held2", int'(din_ready), 0);
    step_chk("t5.a2", 561, 0, 0, 0);
    step_chk("t5.a3", 330, 1, 0, 0);
    step_chk("t5.b0", 100, 0, 0, 0);
    step_chk("t5.b1", 175, 0, 0, 0);
    step_chk("t5.b2", 250, 0, 0, 0);
    step_chk("t5.b3", 325, 1, 1, 0);
    step_chk("t5.s0", 400, 0, 0, 1);

    // 6: starved at 400, supply 0 -> clears at next wrap, ramps down
    din = 11'sd0; din_valid = 1'b1;
    step_chk("t6.s1", 400, 0, 0, 1);
    din_valid = 1'b0;
    step_chk("t6.s2", 400, 0, 0, 1);
    step_chk("t6.s3", 400, 1, 0, 1);
    step_chk("t6.r0", 400, 0, 0, 0);
    din = -11'sd300; din_valid = 1'b1;
    step_chk("t6.r1", 300, 0, 0, 0);
    din_valid = 1'b0;
    step_chk("t6.r2", 200, 0, 0, 0);

    // reset mid-ramp with a sample waiting in hold: both are discarded
    rst = 1'b1;
    #1;
    check_eq("t6.rst_ready", int'(din_ready), 0);
    step_chk("t6.rst", 0, 0, 0, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step_chk("t6.empty", 0, 0, 0, 0);
      check_eq("t6.empty_ready", int'(din_ready), 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
